// File: rtl/addsub_pipe_nbits.sv
// Pipelined N-bit adder/subtractor: STAGES ripple chunks of W = N/STAGES bits, carry
// registered between chunks, valid/ready flow control with a single global stall.
module addsub_pipe_nbits #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] S,
    output logic         Cout,
    output logic         Ovf
);

    localparam int W = N / STAGES;

    generate
        if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_params
            $error("addsub_pipe_nbits: need N >= 2, 1 <= STAGES <= N, N %% STAGES == 0");
        end
    endgenerate

    // Stage registers; index STAGES-1 is the output register.
    logic         vld_reg [STAGES];
    logic [N-1:0] a_reg   [STAGES];
    logic [N-1:0] b_reg   [STAGES];
    logic [N-1:0] res_reg [STAGES];
    logic         cy_reg  [STAGES];
    logic         ovf_reg;

    // Per-stage inputs (from the previous register, or the ports for stage 0) and next values.
    logic         vld_in  [STAGES];
    logic [N-1:0] a_in    [STAGES];
    logic [N-1:0] b_in    [STAGES];
    logic [N-1:0] res_in  [STAGES];
    logic         cin     [STAGES];
    logic [N-1:0] res_next[STAGES];
    logic         cy_next [STAGES];
    logic         ovf_next;

    logic         advance;
    logic [N-1:0] b_eff;

    assign b_eff     = sub ? ~B : B;
    assign advance   = !vld_reg[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_reg[STAGES-1];
    assign S         = res_reg[STAGES-1];
    assign Cout      = cy_reg[STAGES-1];
    assign Ovf       = ovf_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [W:0] sum;

            if (gi == 0) begin : g_head
                assign vld_in[gi] = in_valid;
                assign a_in[gi]   = A;
                assign b_in[gi]   = b_eff;
                assign res_in[gi] = '0;
                assign cin[gi]    = sub;
            end else begin : g_body
                assign vld_in[gi] = vld_reg[gi-1];
                assign a_in[gi]   = a_reg[gi-1];
                assign b_in[gi]   = b_reg[gi-1];
                assign res_in[gi] = res_reg[gi-1];
                assign cin[gi]    = cy_reg[gi-1];
            end

            assign sum = {1'b0, a_in[gi][gi*W +: W]} + {1'b0, b_in[gi][gi*W +: W]}
                       + (W+1)'(cin[gi]);
            assign cy_next[gi] = sum[W];
            // Bits above the chunks done so far are always zero, so OR merges the new chunk.
            assign res_next[gi] = res_in[gi] | (N'(sum[W-1:0]) << (gi*W));

            if (gi == STAGES - 1) begin : g_tail
                // Carry into bit N-1 recovered from the sum bit and its two operand bits.
                assign ovf_next = (sum[W-1] ^ a_in[gi][N-1] ^ b_in[gi][N-1]) ^ sum[W];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_reg[k] <= 1'b0;
                a_reg[k]   <= '0;
                b_reg[k]   <= '0;
                res_reg[k] <= '0;
                cy_reg[k]  <= 1'b0;
            end
            ovf_reg <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_reg[k] <= vld_in[k];
                if (vld_in[k]) begin
                    a_reg[k]   <= a_in[k];
                    b_reg[k]   <= b_in[k];
                    res_reg[k] <= res_next[k];
                    cy_reg[k]  <= cy_next[k];
                end
            end
            if (vld_in[STAGES-1]) begin
                ovf_reg <= ovf_next;
            end
        end
    end

endmodule
